// File: rtl/seven_seg_scanner.sv
// 4-digit common-anode 7-segment scanner: per-frame digit snapshot, BCD decode,
// optional leading-zero blanking and an all-anodes-off guard at each slot start.
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] thos,
    input  logic [3:0] huns,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic [3:0] dp_en,
    input  logic       blank_lead,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int unsigned DivW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DivW-1:0] DivMax   = DivW'(REFRESH_DIV - 1);
    localparam logic [DivW-1:0] GuardEnd = DivW'(GUARD);

    logic [DivW-1:0]  div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][3:0]  snap_dig_q, snap_dig_d;
    logic [3:0]       snap_dp_q, snap_dp_d;

    logic       slot_end;
    logic       frame_end;
    logic [3:0] digit;
    logic       blank;
    logic [6:0] seg_raw;

    logic [3:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;
    logic       frame_start_d;

    always_comb begin
        slot_end   = (div_q == DivMax);
        frame_end  = slot_end && (idx_q == 2'd3);
        div_d      = slot_end ? '0 : div_q + 1'b1;
        idx_d      = slot_end ? idx_q + 2'd1 : idx_q;
        snap_dig_d = snap_dig_q;
        snap_dp_d  = snap_dp_q;
        // Latch a whole frame's worth of inputs at once so a display never tears.
        if (frame_end) begin
            snap_dig_d = {thos, huns, tens, ones};
            snap_dp_d  = dp_en;
        end
    end

    always_comb begin
        digit = snap_dig_q[idx_q];
        case (idx_q)
            2'd3:    blank = (snap_dig_q[3] == 4'd0);
            2'd2:    blank = (snap_dig_q[3] == 4'd0) && (snap_dig_q[2] == 4'd0);
            2'd1:    blank = (snap_dig_q[3] == 4'd0) && (snap_dig_q[2] == 4'd0) &&
                             (snap_dig_q[1] == 4'd0);
            default: blank = 1'b0;
        endcase
        blank = blank && blank_lead;

        case (digit)
            4'd0:    seg_raw = 7'h40;
            4'd1:    seg_raw = 7'h79;
            4'd2:    seg_raw = 7'h24;
            4'd3:    seg_raw = 7'h30;
            4'd4:    seg_raw = 7'h19;
            4'd5:    seg_raw = 7'h12;
            4'd6:    seg_raw = 7'h02;
            4'd7:    seg_raw = 7'h78;
            4'd8:    seg_raw = 7'h00;
            4'd9:    seg_raw = 7'h10;
            default: seg_raw = 7'h7F;
        endcase
    end

    always_comb begin
        an_d          = 4'hF;
        seg_d         = 7'h7F;
        dp_d          = 1'b1;
        frame_start_d = (div_q == '0) && (idx_q == 2'd0);
        if (div_q >= GuardEnd) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = blank ? 7'h7F : seg_raw;
            dp_d  = ~snap_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            idx_q       <= 2'd0;
            snap_dig_q  <= '0;
            snap_dp_q   <= 4'd0;
            an          <= 4'hF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            snap_dig_q  <= snap_dig_d;
            snap_dp_q   <= snap_dp_d;
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: a cycle-count reference model queues the expected outputs,
// a monitor pops and compares one entry after every clock edge.
module tb_seven_seg_scanner;

    localparam int R = 8;
    localparam int G = 2;
    localparam int FRAME = 4 * R;
    localparam logic [6:0] DEC [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] thos, huns, tens, ones, dp_en;
    logic       blank_lead;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    seven_seg_scanner #(.REFRESH_DIV(R), .GUARD(G)) dut (
        .clk(clk), .reset(reset), .thos(thos), .huns(huns), .tens(tens), .ones(ones),
        .dp_en(dp_en), .blank_lead(blank_lead), .an(an), .seg(seg), .dp(dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    logic [12:0] exp_q [$];
    int checks = 0;
    int passes = 0;

    // Reference model: output of cycle n after reset is a pure function of n and the
    // digits captured at the end of the previous frame.
    int cnt = 0;
    int snap [4] = '{0, 0, 0, 0};
    int snap_dp = 0;

    function automatic logic [6:0] dec(int d);
        if (d > 9) return 7'h7F;
        return DEC[d];
    endfunction

    always @(posedge clk) begin
        int div, slot, msd;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        if (reset) begin
            exp_q.push_back({4'hF, 7'h7F, 1'b1, 1'b0});
            cnt = 0;
            snap = '{0, 0, 0, 0};
            snap_dp = 0;
        end else begin
            div  = cnt % R;
            slot = (cnt / R) % 4;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            if (div >= G) begin
                e_an = 4'hF;
                e_an[slot] = 1'b0;
                // most significant nonzero slot; slot 0 always shown
                msd = 0;
                for (int i = 1; i < 4; i++) if (snap[i] != 0) msd = i;
                e_seg = (blank_lead && slot > msd) ? 7'h7F : dec(snap[slot]);
                e_dp  = ((snap_dp >> slot) & 1) == 0;
            end
            exp_q.push_back({e_an, e_seg, e_dp, (cnt % FRAME) == 0});
            if (cnt % FRAME == FRAME - 1) begin
                snap[0] = ones; snap[1] = tens; snap[2] = huns; snap[3] = thos;
                snap_dp = dp_en;
            end
            cnt++;
        end
    end

    always @(posedge clk) begin
        logic [12:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp, frame_start} !== e)
                $display("FAIL out t=%0t: got an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                         $time, an, seg, dp, frame_start, e[12:9], e[8:2], e[1], e[0]);
            else
                passes++;
        end
    end

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(int t, int h, int te, int o, int d, bit bl);
        thos = 4'(t); huns = 4'(h); tens = 4'(te); ones = 4'(o);
        dp_en = 4'(d); blank_lead = bl;
    endtask

    function automatic int rnd_digit();
        return ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 15));
    endfunction

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 1'b0);
        cycles(3);
        reset = 1'b0;
        cycles(FRAME - 4);
        set_in(1, 2, 5, 0, 0, 1'b0);
        cycles(2 * FRAME);
        set_in(0, 0, 4, 7, 0, 1'b1);
        cycles(2 * FRAME);
        set_in(0, 0, 0, 0, 0, 1'b1);
        cycles(2 * FRAME);
        set_in(1, 2, 5, 0, 0, 1'b0);
        cycles(FRAME + R + 3);
        ones = 4'd1;
        cycles(2 * FRAME);
        set_in(1, 2, 10, 3, 4'b0100, 1'b0);
        cycles(FRAME + 2 * R + 4);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(2 * FRAME);
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 7) == 0)
                set_in(rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit(),
                       int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            reset = ($urandom_range(0, 299) == 0);
            cycles(1);
        end
        reset = 1'b0;
        cycles(3);
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d queued entries, want 0", exp_q.size());
        else
            passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
